// File: rtl/neighbor_bank_router.sv
// neighbor_bank_router: pops neighbor requests from a FIFO one at a time,
// decodes the target bank from the address MSBs, waits for that bank to be
// free and issues a one-cycle one-hot request with tag and bank-local address.
// Optional per-bank issue / drop statistics: define NEIGHBOR_ROUTE_STATS_EN.
//
// state | meaning
// IDLE  | waiting for the FIFO to become non-empty
// POP   | fifo_rinc high for one cycle
// CAPT  | FIFO read data valid this cycle; latch it or drop it
// HOLD  | entry held, waiting for its bank to be free, then issue
module neighbor_bank_router #(
    parameter int NUM_BANKS   = 4,
    parameter int ADDR_W      = 10,
    parameter int TAG_W       = 4,
    parameter int STALL_LIMIT = 255,
    parameter int CNT_W       = 16,
    localparam int SEL_W      = $clog2(NUM_BANKS),
    localparam int BA_W       = ADDR_W - SEL_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_rinc,
    input  logic                 fifo_valid,
    input  logic [ADDR_W-1:0]    fifo_addr,
    input  logic [TAG_W-1:0]     fifo_tag,
    input  logic [NUM_BANKS-1:0] bank_busy,
    output logic [NUM_BANKS-1:0] bank_req_valid,
    output logic [TAG_W-1:0]     bank_req_tag,
    output logic [BA_W-1:0]      bank_req_addr,
    output logic                 stall_err,
`ifdef NEIGHBOR_ROUTE_STATS_EN
    output logic [NUM_BANKS*CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
`endif
    output logic                 busy
);

    localparam int STL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [STL_W-1:0] STALL_MAX = STL_W'(STALL_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPT, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    hold_addr_q, hold_addr_d;
    logic [TAG_W-1:0]     hold_tag_q, hold_tag_d;
    logic [STL_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [STL_W-1:0]     stall_inc;
    logic [NUM_BANKS-1:0] req_valid_q, req_valid_d;
    logic [TAG_W-1:0]     req_tag_q, req_tag_d;
    logic [BA_W-1:0]      req_addr_q, req_addr_d;
    logic                 stall_err_q, stall_err_d;
    logic [SEL_W-1:0]     sel;
    logic                 issue_fire;

    assign sel        = hold_addr_q[ADDR_W-1 -: SEL_W];
    assign issue_fire = (state_q == S_HOLD) && !bank_busy[sel];
    assign stall_inc  = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + STL_W'(1);

    // Next-state, hold register, issue registers and watchdog update.
    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_tag_d  = hold_tag_q;
        stall_cnt_d = stall_cnt_q;
        req_valid_d = '0;
        req_tag_d   = req_tag_q;
        req_addr_d  = req_addr_q;
        stall_err_d = stall_err_q;
        fifo_rinc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_POP;
            end
            S_POP: begin
                fifo_rinc = 1'b1;
                state_d   = S_CAPT;
            end
            S_CAPT: begin
                hold_addr_d = fifo_addr;
                hold_tag_d  = fifo_tag;
                if (fifo_valid) begin
                    state_d     = S_HOLD;
                    stall_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (issue_fire) begin
                    req_valid_d = NUM_BANKS'(1) << sel;
                    req_tag_d   = hold_tag_q;
                    req_addr_d  = hold_addr_q[BA_W-1:0];
                    state_d     = fifo_empty ? S_IDLE : S_POP;
                end else begin
                    stall_cnt_d = stall_inc;
                    if (stall_inc == STALL_MAX) stall_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_addr_q <= '0;
            hold_tag_q  <= '0;
            stall_cnt_q <= '0;
            req_valid_q <= '0;
            req_tag_q   <= '0;
            req_addr_q  <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_tag_q  <= hold_tag_d;
            stall_cnt_q <= stall_cnt_d;
            req_valid_q <= req_valid_d;
            req_tag_q   <= req_tag_d;
            req_addr_q  <= req_addr_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign bank_req_valid = req_valid_q;
    assign bank_req_tag   = req_tag_q;
    assign bank_req_addr  = req_addr_q;
    assign stall_err      = stall_err_q;
    assign busy           = (state_q != S_IDLE);

`ifdef NEIGHBOR_ROUTE_STATS_EN
    logic [NUM_BANKS*CNT_W-1:0] issue_cnt_q;
    logic [CNT_W-1:0]           drop_cnt_q;
    logic                       drop_fire;

    assign drop_fire = (state_q == S_CAPT) && !fifo_valid;

    // Per-bank issue counters and drop counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (issue_fire && (sel == SEL_W'(b)) && !(&issue_cnt_q[b*CNT_W +: CNT_W]))
                    issue_cnt_q[b*CNT_W +: CNT_W] <= issue_cnt_q[b*CNT_W +: CNT_W] + CNT_W'(1);
            end
            if (drop_fire && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_neighbor_bank_router.sv
// Testbench for neighbor_bank_router: directed scenarios followed by random
// traffic, all checked every cycle against a cycle-timestamp reference model.
module tb_neighbor_bank_router;

    localparam int NB  = 4;
    localparam int AW  = 10;
    localparam int TW  = 4;
    localparam int LIM = 4;
    localparam int BA  = 8;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rinc;
    logic          fifo_valid = 1'b0;
    logic [AW-1:0] fifo_addr = '0;
    logic [TW-1:0] fifo_tag = '0;
    logic [NB-1:0] bank_busy = '0;
    logic [NB-1:0] bank_req_valid;
    logic [TW-1:0] bank_req_tag;
    logic [BA-1:0] bank_req_addr;
    logic          stall_err;
    logic          busy;
`ifdef NEIGHBOR_ROUTE_STATS_EN
    logic [NB*CW-1:0] issue_cnt;
    logic [CW-1:0]    drop_cnt;
`endif

    always #5 clk = ~clk;

    neighbor_bank_router #(
        .NUM_BANKS(NB), .ADDR_W(AW), .TAG_W(TW), .STALL_LIMIT(LIM), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .fifo_empty(fifo_empty), .fifo_rinc(fifo_rinc), .fifo_valid(fifo_valid),
        .fifo_addr(fifo_addr), .fifo_tag(fifo_tag),
        .bank_busy(bank_busy), .bank_req_valid(bank_req_valid),
        .bank_req_tag(bank_req_tag), .bank_req_addr(bank_req_addr),
        .stall_err(stall_err),
`ifdef NEIGHBOR_ROUTE_STATS_EN
        .issue_cnt(issue_cnt), .drop_cnt(drop_cnt),
`endif
        .busy(busy)
    );

    typedef struct packed {
        logic          v;
        logic [AW-1:0] a;
        logic [TW-1:0] t;
    } ent_t;

    ent_t fifo_q[$];
    ent_t in_flight = '0;
    ent_t drv_e     = '0;
    ent_t hold_e    = '0;
    bit   data_pending = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model: cycle timestamps of the next expected events
    int            pop_at = -1;
    int            capt_at = -1;
    int            idle_at = 0;
    bit            hold = 1'b0;
    int            hold_from = 0;
    int            stall_run = 0;
    bit            err_m = 1'b0;
    bit [NB-1:0]   exp_valid = '0;
    bit [TW-1:0]   exp_tag = '0;
    bit [BA-1:0]   exp_addr = '0;
    int            exp_issue[NB];
    int            exp_drop = 0;

    bit            rst_drive = 1'b1;
    bit [NB-1:0]   busy_drive = '0;

    int            rinc_cyc = -1;
    int            err_cyc = -1;
    int            issue_cycs[$];
    bit [NB-1:0]   issue_vals[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic ent_t mk(input int bank, input int baddr, input int tag, input bit v);
        ent_t e;
        e.v = v;
        e.a = AW'((bank << BA) | (baddr & ((1 << BA) - 1)));
        e.t = TW'(tag);
        return e;
    endfunction

    task automatic clear_logs();
        rinc_cyc = -1;
        err_cyc = -1;
        issue_cycs.delete();
        issue_vals.delete();
    endtask

    // One clock: check outputs of this cycle, drive inputs, advance the model.
    task automatic step();
        int sel;
        @(negedge clk);
        chk("rinc", 32'(fifo_rinc), 32'(pop_at == cyc));
        chk("req_valid", 32'(bank_req_valid), 32'(exp_valid));
        chk("req_tag", 32'(bank_req_tag), 32'(exp_tag));
        chk("req_addr", 32'(bank_req_addr), 32'(exp_addr));
        chk("stall_err", 32'(stall_err), 32'(err_m));
        chk("busy", 32'(busy), 32'(idle_at != cyc));
`ifdef NEIGHBOR_ROUTE_STATS_EN
        for (int b = 0; b < NB; b++)
            chk("issue_cnt", 32'(issue_cnt[b*CW +: CW]), 32'(exp_issue[b]));
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
`endif
        if (fifo_rinc === 1'b1 && rinc_cyc < 0) rinc_cyc = cyc;
        if (stall_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
        if (bank_req_valid !== '0) begin
            issue_cycs.push_back(cyc);
            issue_vals.push_back(bank_req_valid);
        end

        // FIFO read data follows the pop strobe by one cycle; garbage otherwise
        if (data_pending) begin
            fifo_valid = in_flight.v;
            fifo_addr  = in_flight.a;
            fifo_tag   = in_flight.t;
            drv_e      = in_flight;
        end else begin
            fifo_valid = 1'($urandom);
            fifo_addr  = AW'($urandom);
            fifo_tag   = TW'($urandom);
        end
        data_pending = 1'b0;
        if (fifo_rinc === 1'b1) begin
            in_flight = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
            data_pending = 1'b1;
        end
        fifo_empty = (fifo_q.size() == 0);
        bank_busy  = busy_drive;
        reset      = !rst_drive;

        exp_valid = '0;
        if (rst_drive) begin
            pop_at = -1; capt_at = -1; idle_at = cyc + 1;
            hold = 1'b0; stall_run = 0; err_m = 1'b0;
            exp_tag = '0; exp_addr = '0; exp_drop = 0;
            for (int b = 0; b < NB; b++) exp_issue[b] = 0;
            data_pending = 1'b0;
        end else begin
            if (hold && hold_from <= cyc) begin
                sel = int'(hold_e.a >> BA);
                if (!busy_drive[sel]) begin
                    exp_valid = NB'(1) << sel;
                    exp_tag   = hold_e.t;
                    exp_addr  = hold_e.a[BA-1:0];
                    hold      = 1'b0;
                    if (exp_issue[sel] < (1 << CW) - 1) exp_issue[sel]++;
                    if (!fifo_empty) pop_at = cyc + 1; else idle_at = cyc + 1;
                end else begin
                    if (stall_run < LIM) stall_run++;
                    if (stall_run == LIM) err_m = 1'b1;
                end
            end
            if (capt_at == cyc) begin
                if (drv_e.v) begin
                    hold = 1'b1; hold_e = drv_e; hold_from = cyc + 1; stall_run = 0;
                end else begin
                    idle_at = cyc + 1;
                    if (exp_drop < (1 << CW) - 1) exp_drop++;
                end
            end
            if (pop_at == cyc) capt_at = cyc + 1;
            if (idle_at == cyc) begin
                if (!fifo_empty) pop_at = cyc + 1; else idle_at = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        busy_drive = '0;
        rst_drive = 1'b1;
        repeat (n) step();
        rst_drive = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int t0;
        ent_t e;
        for (int b = 0; b < NB; b++) exp_issue[b] = 0;

        // reset state, then single-entry latency
        do_reset(3);
        chk("rst_valid", 32'(bank_req_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        clear_logs();
        t0 = cyc;
        fifo_q.push_back(mk(2, 8'h05, 3, 1'b1));
        repeat (8) step();
        chk("t1_rinc_lat", 32'(rinc_cyc - t0), 32'd1);
        chk("t1_issue_n", 32'(issue_cycs.size()), 32'd1);
        if (issue_cycs.size() > 0) begin
            chk("t1_issue_lat", 32'(issue_cycs[0] - t0), 32'd4);
            chk("t1_onehot", 32'(issue_vals[0]), 32'b0100);
        end
        chk("t1_tag", 32'(bank_req_tag), 32'd3);
        chk("t1_addr", 32'(bank_req_addr), 32'h05);

        // bank 2 busy for 5 HOLD cycles, bank 0 toggling; watchdog trips at 4
        clear_logs();
        t0 = cyc;
        fifo_q.push_back(mk(2, 8'h05, 3, 1'b1));
        for (int i = 0; i < 12; i++) begin
            busy_drive = '0;
            busy_drive[2] = (i <= 7);
            busy_drive[0] = i[0];
            step();
        end
        busy_drive = '0;
        chk("t2_issue_n", 32'(issue_cycs.size()), 32'd1);
        if (issue_cycs.size() > 0) chk("t2_issue_lat", 32'(issue_cycs[0] - t0), 32'd9);
        chk("t2_err_rise", 32'(err_cyc - t0), 32'd7);
        chk("t2_err_sticky", 32'(stall_err), 32'd1);

        // three queued entries to banks 0,1,3 back to back
        do_reset(2);
        chk("t3_err_cleared", 32'(stall_err), 32'd0);
        clear_logs();
        t0 = cyc;
        fifo_q.push_back(mk(0, 8'h11, 1, 1'b1));
        fifo_q.push_back(mk(1, 8'h22, 2, 1'b1));
        fifo_q.push_back(mk(3, 8'h33, 9, 1'b1));
        repeat (14) step();
        chk("t3_issue_n", 32'(issue_cycs.size()), 32'd3);
        if (issue_cycs.size() == 3) begin
            chk("t3_first", 32'(issue_cycs[0] - t0), 32'd4);
            chk("t3_gap1", 32'(issue_cycs[1] - issue_cycs[0]), 32'd3);
            chk("t3_gap2", 32'(issue_cycs[2] - issue_cycs[1]), 32'd3);
            chk("t3_oh0", 32'(issue_vals[0]), 32'b0001);
            chk("t3_oh1", 32'(issue_vals[1]), 32'b0010);
            chk("t3_oh2", 32'(issue_vals[2]), 32'b1000);
        end

        // invalid entry is dropped
        clear_logs();
        fifo_q.push_back(mk(1, 8'h44, 5, 1'b0));
        repeat (8) step();
        chk("t4_no_issue", 32'(issue_cycs.size()), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);
`ifdef NEIGHBOR_ROUTE_STATS_EN
        chk("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // reset while in HOLD discards the entry
        clear_logs();
        fifo_q.push_back(mk(1, 8'h66, 7, 1'b1));
        busy_drive = 4'b0010;
        repeat (4) step();
        rst_drive = 1'b1;
        busy_drive = '0;
        step();
        rst_drive = 1'b0;
        step();
        chk("t5_rst_tag", 32'(bank_req_tag), 32'd0);
        chk("t5_rst_addr", 32'(bank_req_addr), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        repeat (10) step();
        chk("t5_no_issue", 32'(issue_cycs.size()), 32'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) begin
                e.v = ($urandom_range(0, 9) != 0);
                e.a = AW'($urandom);
                e.t = TW'($urandom);
                fifo_q.push_back(e);
            end
            if ((i / 500) % 2 == 0) busy_drive = NB'($urandom & $urandom);
            else                    busy_drive = NB'($urandom | $urandom);
            rst_drive = ($urandom_range(0, 199) == 0);
            step();
        end
        rst_drive = 1'b0;
        busy_drive = '0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
